rr_mux2_stream: RTL
===================

# rr_mux2_stream

Two-input round-robin stream arbiter that sits directly upstream of the 2:1 mux datapath. It decides each cycle which of two valid/ready sources wins, registers the winning word, and drives `sel` to the existing `mux2` select input (`j`). A burst limit bounds how long one source may hold the output while the other waits.

## Interface
- `W`, default 8: data width of each source and of the output.
- `BURST`, default 4: maximum consecutive grants to one source while the other is requesting. Legal range is BURST >= 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `v0`  in  1: source 0 valid.
- `d0`  in  W: source 0 data.
- `r0`  out  1: source 0 ready (combinational).
- `v1`  in  1: source 1 valid.
- `d1`  in  W: source 1 data.
- `r1`  out  1: source 1 ready (combinational).
- `ov`  out  1: output valid (registered).
- `od`  out  W: output data (registered).
- `ordy`  in  1: downstream ready.
- `sel`  out  1: source index of the word currently in `od` (registered); feeds `mux2.j`.

## Operation
- Internal state:
  - `last` (1 b): most recently granted source.
  - `cnt` (clog2(BURST+1) b): consecutive grants to `last`, saturating at BURST.
- `accept = !ov || ordy`. The output register can take a new word this cycle.
- Grant choice `g`, evaluated when `accept` is high:
  - Only v0 is high: g = 0.
  - Only v1 is high: g = 1.
  - Both are high: g = `last` if cnt < BURST, else g = ~last.
  - Neither is high: no grant.
- Ready outputs:
  - r0 = accept && grant && g == 0.
  - r1 = accept && grant && g == 1.
  - At most one ready is high in any cycle.
  - Ready may depend on the valids. Valid must never depend on ready.
- On a grant (clock edge):
  - od <= d_g, sel <= g, ov <= 1.
  - If g == last: cnt <= min(cnt+1, BURST).
  - Else: last <= g, cnt <= 1.
- `accept` high with no valid: ov <= 0. od, sel, last and cnt hold.
- `accept` low (ov=1, ordy=0): od, sel, ov, last and cnt all hold; r0 = r1 = 0.
- Starvation guard: when only `last` is requesting, cnt sits at BURST. The moment the other source asserts valid, it wins on the next grant.
- BURST = 1 gives strict alternation under contention.

## Timing
- Reset values (asynchronous, take effect immediately without a clock edge):
  - ov = 0, od = 0, sel = 0.
  - last = 0, cnt = 0.
  - r0 and r1 follow the combinational rule, so they are 0 while v0 and v1 are 0.
- Reset mid-operation: the in-flight `od` word is dropped. After release, the first tie grants source 0.
- Latency: one cycle from the input handshake (v_g && r_g at an edge) to ov=1 with that data.
- Throughput: one word per cycle while ordy = 1 and any valid is high. There are no bubbles on a source switch.
- Simultaneous events:
  - Downstream consume (ov && ordy) and new grant in the same cycle: the register is replaced with the new word, and ov stays 1.
  - Consume with no valid: ov falls at that edge.
- Contention pattern with ordy held at 1: runs of BURST grants to each source, alternating.

## Test plan
- Reset: hold rst=1 with v0=v1=0. Required: ov=0, od=0x00, sel=0, r0=r1=0. Assert rst asynchronously mid-stream: ov drops before the next clock edge.
- Single source, W=8, ordy=1: v0=1 with d0=0x11, 0x12, 0x13 on consecutive cycles. Required: od=0x11, 0x12, 0x13 on the following cycles with sel=0; r1 stays 0.
- Contention, BURST=4, v0=v1=1, ordy=1, for 12 cycles. Required: sel=0,0,0,0,1,1,1,1,0,0,0,0; each output word matches the granted source's data.
- Backpressure: ov=1 with od=0x22, then ordy=0 for 3 cycles. Required: od and sel hold, r0=r1=0. Raise ordy: the next grant loads on that edge and ov stays 1.
- Burst guard: v0=1 alone for 6 cycles (cnt saturates at 4), then raise v1. Required: the next grant goes to source 1 (sel=1).
- BURST=1 with v0=v1=1. Required: sel=0,1,0,1,…

Source files
------------

// File: rtl/rr_mux2_stream.sv
// Two-input round-robin stream arbiter with a burst limit; registers the winner and its index for mux2.j.
// Latency: one cycle from input handshake to ov/od/sel.
// Backpressure: r0/r1 are low while ov=1 and ordy=0; the output register and arbitration state hold.
module rr_mux2_stream #(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         v0,
    input  logic [W-1:0] d0,
    output logic         r0,
    input  logic         v1,
    input  logic [W-1:0] d1,
    output logic         r1,
    output logic         ov,
    output logic [W-1:0] od,
    input  logic         ordy,
    output logic         sel
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic          ov_q,   ov_d;
    logic [W-1:0]  od_q,   od_d;
    logic          sel_q,  sel_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    logic accept;
    logic grant;
    logic g;

    always_comb begin
        accept = !ov_q || ordy;
        grant  = accept && (v0 || v1);
        // Under contention the current owner keeps the output until its run reaches BURST.
        if (v0 && v1) begin
            g = (cnt_q < BURST_C) ? last_q : !last_q;
        end else begin
            g = v1;
        end
    end

    assign r0 = grant && !g;
    assign r1 = grant && g;

    always_comb begin
        ov_d   = ov_q;
        od_d   = od_q;
        sel_d  = sel_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (grant) begin
            ov_d  = 1'b1;
            od_d  = g ? d1 : d0;
            sel_d = g;
            if (g == last_q) begin
                cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_q + ONE_C;
            end else begin
                last_d = g;
                cnt_d  = ONE_C;
            end
        end else if (accept) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q   <= 1'b0;
            od_q   <= '0;
            sel_q  <= 1'b0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ov_q   <= ov_d;
            od_q   <= od_d;
            sel_q  <= sel_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ov  = ov_q;
    assign od  = od_q;
    assign sel = sel_q;
endmodule
